dangling_output: RTL and testbench

Cleanup test design for the netlist-cleanup flow, exercising the opposite case to an unused input port: a sub-module output port that the parent never reads. `seq_source` produces a valid/ready stream of incrementing data plus a debug beat counter. The top, `dangling_output`, consumes the stream, sums fixed-length packets and presents each sum with a hold-until-ready handshake. The debug counter output is left unconnected in the parent, so cleanup must remove that port and its driving logic without changing top-level behaviour.

---
 rtl/dangling_pkg.sv | 32 +++
 rtl/seq_source.sv | 109 ++++++++++
 rtl/dangling_output.sv | 104 ++++++++++
 tb/tb_dangling_output.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dangling_pkg.sv
// Shared types and constants for the dangling_output block.
// - src_state_t : seq_source FSM states (IDLE, RUN)
// - top_state_t : packet accumulator FSM states (ACCUM, HOLD)
// - DEBUG_W / DEBUG_MAX : width and saturation value of the debug beat counter
// - sat_inc() : saturating increment used by the debug counter
package dangling_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } src_state_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } top_state_t;

  localparam int DEBUG_W = 16;
  localparam logic [DEBUG_W-1:0] DEBUG_MAX = 16'hFFFF;

  // Increment that sticks at DEBUG_MAX instead of wrapping.
  function automatic logic [DEBUG_W-1:0] sat_inc(input logic [DEBUG_W-1:0] value);
    logic [DEBUG_W-1:0] res;
    if (value == DEBUG_MAX) begin
      res = value;
    end else begin
      res = value + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_source.sv
// Valid/ready source of incrementing data, grouped into BEATS-long packets.
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   enable            : allows a new beat to be started
//   src_ready         : consumer accepts the presented beat
//   src_valid         : a beat is presented (never retracted until accepted)
//   src_data[WIDTH]   : beat payload, increments per accepted beat, wraps
//   src_last          : presented beat is the last of its packet
//   debug_count[16]   : saturating count of accepted beats (debug only)
module seq_source
  import dangling_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BEATS = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               src_ready,
  output logic               src_valid,
  output logic [WIDTH-1:0]   src_data,
  output logic               src_last,
  output logic [DEBUG_W-1:0] debug_count
);

  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  src_state_t         state_r, state_next_s;
  logic               valid_r, valid_next_s;
  logic [WIDTH-1:0]   data_r, data_next_s;
  logic [IDX_W-1:0]   idx_r, idx_next_s;
  logic               last_r, last_next_s;
  logic [DEBUG_W-1:0] debug_r, debug_next_s;
  logic               accept_s;

  // Next-state logic: data, index and last only advance on an accepted beat,
  // so a presented beat stays intact while stalled or after enable falls.
  always_comb begin
    state_next_s = state_r;
    valid_next_s = valid_r;
    data_next_s  = data_r;
    idx_next_s   = idx_r;
    last_next_s  = last_r;
    debug_next_s = debug_r;
    accept_s     = valid_r & src_ready;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_next_s = RUN;
          valid_next_s = 1'b1;
        end else begin
          state_next_s = IDLE;
          valid_next_s = 1'b0;
        end
      end
      RUN: begin
        if (accept_s) begin
          data_next_s = data_r + WIDTH'(1);
          if (idx_r == LAST_IDX) begin
            idx_next_s = '0;
          end else begin
            idx_next_s = idx_r + IDX_W'(1);
          end
          last_next_s  = (idx_next_s == LAST_IDX);
          debug_next_s = sat_inc(debug_r);
          if (enable) begin
            state_next_s = RUN;
            valid_next_s = 1'b1;
          end else begin
            state_next_s = IDLE;
            valid_next_s = 1'b0;
          end
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = IDLE;
        valid_next_s = 1'b0;
      end
    endcase
  end

  // State and beat registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      valid_r <= 1'b0;
      data_r  <= '0;
      idx_r   <= '0;
      last_r  <= 1'b0;
      debug_r <= '0;
    end else begin
      state_r <= state_next_s;
      valid_r <= valid_next_s;
      data_r  <= data_next_s;
      idx_r   <= idx_next_s;
      last_r  <= last_next_s;
      debug_r <= debug_next_s;
    end
  end

  assign src_valid   = valid_r;
  assign src_data    = data_r;
  assign src_last    = last_r;
  assign debug_count = debug_r;

endmodule

// File: rtl/dangling_output.sv
// Packet summer: consumes the seq_source stream, adds up each BEATS-long
// packet modulo 2^WIDTH and holds the sum until the downstream takes it.
// The source's debug_count output is deliberately left unconnected.
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   enable        : lets the source start new beats
//   ready         : downstream accepts result while result_valid is high
//   result[WIDTH] : packet sum (registered)
//   result_valid  : result is valid (registered)
module dangling_output
  import dangling_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BEATS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  top_state_t       state_r, state_next_s;
  logic [WIDTH-1:0] acc_r, acc_next_s;
  logic [WIDTH-1:0] result_r, result_next_s;
  logic             result_valid_r, result_valid_next_s;
  logic             src_ready_s;
  logic             src_valid_s;
  logic [WIDTH-1:0] src_data_s;
  logic             src_last_s;

  seq_source #(
    .WIDTH (WIDTH),
    .BEATS (BEATS)
  ) u_src (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .src_ready   (src_ready_s),
    .src_valid   (src_valid_s),
    .src_data    (src_data_s),
    .src_last    (src_last_s),
    .debug_count ()
  );

  // Accumulate in ACCUM; a last beat publishes the sum and parks in HOLD,
  // where the stream is stalled until the result is taken.
  always_comb begin
    state_next_s        = state_r;
    acc_next_s          = acc_r;
    result_next_s       = result_r;
    result_valid_next_s = result_valid_r;
    src_ready_s         = (state_r == ACCUM);
    case (state_r)
      ACCUM: begin
        if (src_valid_s) begin
          if (src_last_s) begin
            result_next_s       = acc_r + src_data_s;
            result_valid_next_s = 1'b1;
            acc_next_s          = '0;
            state_next_s        = HOLD;
          end else begin
            acc_next_s   = acc_r + src_data_s;
            state_next_s = ACCUM;
          end
        end else begin
          state_next_s = ACCUM;
        end
      end
      HOLD: begin
        if (ready) begin
          result_valid_next_s = 1'b0;
          state_next_s        = ACCUM;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        result_valid_next_s = 1'b0;
        state_next_s        = ACCUM;
      end
    endcase
  end

  // Accumulator, result and FSM registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= ACCUM;
      acc_r          <= '0;
      result_r       <= '0;
      result_valid_r <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      acc_r          <= acc_next_s;
      result_r       <= result_next_s;
      result_valid_r <= result_valid_next_s;
    end
  end

  assign result       = result_r;
  assign result_valid = result_valid_r;

endmodule

// File: tb/tb_dangling_output.sv
// Self-checking bench for dangling_output. Expected sums come from the
// packet rule: packet p covers data values start..start+BEATS-1 (mod 2^WIDTH)
// and its result is their sum mod 2^WIDTH.
module tb_dangling_output;

  localparam int WIDTH = 8;
  localparam int BEATS = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             ready;
  logic [WIDTH-1:0] result;
  logic             result_valid;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] next_start;
  logic [WIDTH-1:0] held_v;

  always #5 clock = ~clock;

  dangling_output #(
    .WIDTH (WIDTH),
    .BEATS (BEATS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .ready        (ready),
    .result       (result),
    .result_valid (result_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] model_sum(input logic [WIDTH-1:0] start);
    int s;
    s = 0;
    for (int i = 0; i < BEATS; i++) begin
      s = s + ((int'(start) + i) % (1 << WIDTH));
    end
    s = s % (1 << WIDTH);
    return s[WIDTH-1:0];
  endfunction

  // Wait for the next result (random ready meanwhile), check latency and sum,
  // then hold it with random backpressure and release it.
  task automatic drain(input int exp_lat);
    int               n;
    int               m;
    bit               r;
    logic [WIDTH-1:0] exp_v;
    exp_v = model_sum(next_start);
    n = 0;
    while (result_valid !== 1'b1 && n < 50) begin
      ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("result_seen", 32'(result_valid), 32'd1);
    chk("latency", n, exp_lat);
    chk("result", 32'(result), 32'(exp_v));
    next_start = next_start + WIDTH'(BEATS);
    m = 0;
    do begin
      if (m >= 6) r = 1'b1;
      else        r = 1'($urandom_range(0, 1));
      ready = r;
      tick();
      m++;
      if (r == 1'b0) begin
        chk("hold_valid", 32'(result_valid), 32'd1);
        chk("hold_result", 32'(result), 32'(exp_v));
        chk("hold_src_ready", 32'(dut.src_ready_s), 32'd0);
      end
    end while (r == 1'b0);
    chk("release_valid", 32'(result_valid), 32'd0);
    chk("release_src_ready", 32'(dut.src_ready_s), 32'd1);
    chk("next_packet_data", 32'(dut.src_data_s), 32'(next_start));
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    ready  = 1'b0;
    next_start = '0;
    repeat (3) tick();
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_valid", 32'(result_valid), 32'd0);
    chk("reset_src_valid", 32'(dut.src_valid_s), 32'd0);
    chk("reset_src_data", 32'(dut.src_data_s), 32'd0);

    // Startup: first beat valid after the enabling edge, result one cycle
    // after the last of four beats.
    reset  = 1'b0;
    enable = 1'b1;
    ready  = 1'b1;
    for (int k = 1; k <= BEATS + 1; k++) begin
      tick();
      if (k == 1) chk("first_beat_valid", 32'(dut.src_valid_s), 32'd1);
      chk("startup_valid", 32'(result_valid), 32'(k == BEATS + 1));
    end
    held_v = model_sum(next_start);
    chk("first_result", 32'(result), 32'(held_v));
    next_start = next_start + WIDTH'(BEATS);

    // Backpressure: five HOLD cycles with ready low.
    ready = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_valid", 32'(result_valid), 32'd1);
      chk("bp_result", 32'(result), 32'(held_v));
      chk("bp_src_ready", 32'(dut.src_ready_s), 32'd0);
      chk("bp_src_data", 32'(dut.src_data_s), 32'(next_start));
    end
    ready = 1'b1;
    tick();
    chk("bp_release", 32'(result_valid), 32'd0);
    drain(BEATS);

    // Enable gap after beat 1: source idles, partial sum is kept.
    tick();
    enable = 1'b0;
    tick();
    chk("gap_src_idle", 32'(dut.src_valid_s), 32'd0);
    repeat (3) begin
      tick();
      chk("gap_src_valid", 32'(dut.src_valid_s), 32'd0);
      chk("gap_result_valid", 32'(result_valid), 32'd0);
      chk("gap_src_data", 32'(dut.src_data_s), 32'(next_start + WIDTH'(2)));
    end
    enable = 1'b1;
    drain(BEATS - 1);

    // Reset after beat 2 clears outputs without waiting for a clock edge.
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async_result", 32'(result), 32'd0);
    chk("async_valid", 32'(result_valid), 32'd0);
    chk("async_src_valid", 32'(dut.src_valid_s), 32'd0);
    chk("async_src_data", 32'(dut.src_data_s), 32'd0);
    tick();
    reset = 1'b0;
    next_start = '0;
    drain(BEATS + 1);

    // Long run with random ready, crossing the data wrap.
    repeat (70) drain(BEATS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
